// File: rtl/timer_pkg.sv
// Shared constants for the timer/counter block:
// widths, prescaler select encodings and count direction.
package timer_pkg;

  localparam int CNT_W = 8;
  localparam int CKS_W = 2;
  localparam int DIV_W = 4;

  localparam logic [CKS_W-1:0] CKS_DIV2  = 2'd0;
  localparam logic [CKS_W-1:0] CKS_DIV4  = 2'd1;
  localparam logic [CKS_W-1:0] CKS_DIV8  = 2'd2;
  localparam logic [CKS_W-1:0] CKS_DIV16 = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Low (cks+1) bits of the prescaler that must all be set for a tick
  function automatic logic [DIV_W-1:0] cks_mask(
    input logic [CKS_W-1:0] cks
  );
    logic [DIV_W-1:0] m;
    m = 4'hF;
    unique case (cks)
      CKS_DIV2:  m = 4'h1;
      CKS_DIV4:  m = 4'h3;
      CKS_DIV8:  m = 4'h7;
      CKS_DIV16: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit prescaler with select-dependent tick decode.
// Holds while disabled; cleared by reset or counter load.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int CKS_W = timer_pkg::CKS_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             enable,
  input  logic             clr,
  input  logic [CKS_W-1:0] cks,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] mask;

  assign mask = cks_mask(cks);
  assign tick = enable & ((div_cnt & mask) == mask);

  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Up/down timer counter stepped by the prescaler tick.
// Wraps silently; overflow detection lives downstream.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = timer_pkg::CNT_W,
  parameter int CKS_W = timer_pkg::CKS_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [CNT_W-1:0] tdr,
  input  logic [CKS_W-1:0] cks,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] last_counter,
  output logic             count_tick
);

  logic tick;

  timer_prescaler #(
    .CKS_W(CKS_W)
  ) u_prescaler (
    .pclk    (pclk),
    .preset_n(preset_n),
    .enable  (enable),
    .clr     (load),
    .cks     (cks),
    .tick    (tick)
  );

  // Load wins over a coincident tick; both step and pulse are dropped
  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      counter      <= '0;
      last_counter <= '0;
      count_tick   <= 1'b0;
    end else begin
      last_counter <= counter;
      count_tick   <= tick & ~load;
      if (load) begin
        counter <= tdr;
      end else if (tick) begin
        if (up_down == DIR_DOWN)
          counter <= counter - CNT_W'(1);
        else
          counter <= counter + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_timer_counter;

  logic       pclk;
  logic       preset_n;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [7:0] tdr;
  logic [1:0] cks;
  logic [7:0] counter;
  logic [7:0] last_counter;
  logic       count_tick;

  int n_vec;
  int n_err;
  int n_tick;
  int n_wrap;

  timer_counter dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .enable      (enable),
    .up_down     (up_down),
    .load        (load),
    .tdr         (tdr),
    .cks         (cks),
    .counter     (counter),
    .last_counter(last_counter),
    .count_tick  (count_tick)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    preset_n = 1'b1;
    enable   = 1'b0;
    up_down  = 1'b0;
    load     = 1'b0;
    tdr      = 8'h00;
    cks      = 2'd0;
    step();
    step();
    chk("rst_counter", 32'(counter), 32'h00);
    chk("rst_last", 32'(last_counter), 32'h00);
    chk("rst_tick", 32'(count_tick), 32'h0);

    // /2 up-count from reset
    preset_n = 1'b0;
    enable   = 1'b1;
    n_tick   = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (count_tick) n_tick++;
      chk($sformatf("up2_cnt_%0d", k), 32'(counter), 32'(k / 2));
    end
    chk("up2_final", 32'(counter), 32'h05);
    chk("up2_ticks", 32'(n_tick), 32'd5);

    // load 0xFE then /4 up-count through the wrap
    load = 1'b1;
    tdr  = 8'hFE;
    cks  = 2'd1;
    step();
    chk("ld_fe_cnt", 32'(counter), 32'hFE);
    chk("ld_fe_tick", 32'(count_tick), 32'h0);
    load   = 1'b0;
    n_wrap = 0;
    for (int k = 1; k <= 12; k++) begin
      logic [7:0] e;
      step();
      e = 8'hFE + 8'(k / 4);
      chk($sformatf("up4_cnt_%0d", k), 32'(counter), 32'(e));
      if (last_counter == 8'hFF && counter == 8'h00) n_wrap++;
    end
    chk("wrap_pairs", 32'(n_wrap), 32'd1);

    // load 0x01 then /2 down-count through the wrap
    load    = 1'b1;
    tdr     = 8'h01;
    up_down = 1'b1;
    cks     = 2'd0;
    step();
    chk("ld_01_cnt", 32'(counter), 32'h01);
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [7:0] e;
      step();
      e = 8'h01 - 8'(k / 2);
      chk($sformatf("dn2_cnt_%0d", k), 32'(counter), 32'(e));
    end
    chk("dn_wrap_last", 32'(last_counter), 32'h00);

    // prescaler now at 4; one more edge puts it at 5 (a tick cycle)
    step();
    chk("pre_ld_cnt", 32'(counter), 32'hFF);
    up_down = 1'b0;
    load    = 1'b1;
    tdr     = 8'h40;
    step();
    chk("ldtick_cnt", 32'(counter), 32'h40);
    chk("ldtick_tick", 32'(count_tick), 32'h0);
    load = 1'b0;
    step();
    chk("ldtick_hold", 32'(counter), 32'h40);
    chk("ldtick_hold_t", 32'(count_tick), 32'h0);
    step();
    chk("ldtick_step", 32'(counter), 32'h41);
    chk("ldtick_step_t", 32'(count_tick), 32'h1);

    // prescaler at 2; switch to /16 without restart, then pause
    cks = 2'd3;
    for (int k = 1; k <= 5; k++) step();
    chk("d16_pre", 32'(counter), 32'h41);
    enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("frz_cnt_%0d", k), 32'(counter), 32'h41);
      chk($sformatf("frz_last_%0d", k), 32'(last_counter), 32'h41);
      chk($sformatf("frz_tick_%0d", k), 32'(count_tick), 32'h0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    chk("resume_hold", 32'(counter), 32'h41);
    step();
    chk("resume_step", 32'(counter), 32'h42);
    chk("resume_tick", 32'(count_tick), 32'h1);

    // asynchronous reset between edges at 0x33
    load = 1'b1;
    tdr  = 8'h33;
    cks  = 2'd0;
    step();
    load = 1'b0;
    chk("ld_33_cnt", 32'(counter), 32'h33);
    #2;
    preset_n = 1'b1;
    #1;
    chk("arst_cnt", 32'(counter), 32'h00);
    chk("arst_last", 32'(last_counter), 32'h00);
    chk("arst_tick", 32'(count_tick), 32'h0);
    step();
    #3;
    preset_n = 1'b0;
    step();
    chk("rel_cnt", 32'(counter), 32'h00);
    chk("rel_tick", 32'(count_tick), 32'h0);
    step();
    chk("rel_step_cnt", 32'(counter), 32'h01);
    chk("rel_step_tick", 32'(count_tick), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
